// File: rtl/breath_pwm_multi.sv
// rtl/breath_pwm_multi.sv - multi-channel breathing/fixed/blink LED PWM engine
// Define BREATH_HOLD_EN to make each channel dwell HOLD_PERIODS wraps at its peak/trough.
module breath_pwm_multi #(
  parameter int CH            = 4,
  parameter int CNT_W         = 16,
  parameter int PERIOD        = 50000,
  parameter int STEP          = 25,
  parameter int BLINK_PERIODS = 500,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int HOLD_PERIODS  = 50
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] level,
  output logic [CH-1:0]    led,
  output logic             period_tick,
  output logic             ch0_dir
);
  typedef enum logic [1:0] {MODE_OFF, MODE_BREATHE, MODE_FIXED, MODE_BLINK} mode_e;

  localparam logic [CNT_W-1:0] PER      = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] STP      = CNT_W'(STEP);
  localparam logic [CNT_W:0]   PER_X    = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   STP_X    = (CNT_W+1)'(STEP);
  localparam logic [CNT_W:0]   FULL_X   = (CNT_W+1)'(PERIOD + 1);
  localparam int               BW       = $clog2(BLINK_PERIODS + 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_PERIODS - 1);
  localparam logic [CH-1:0]    UNLIT    = {CH{ACTIVE_LOW}};

  if (STEP < 1 || STEP > PERIOD || (PERIOD >> CNT_W) != 0 || BLINK_PERIODS < 1 || HOLD_PERIODS < 0)
  begin : g_param_check
    $error("breath_pwm_multi: illegal parameter set");
  end

`ifdef BREATH_HOLD_EN
  localparam int            HW        = (HOLD_PERIODS < 1) ? 1 : $clog2(HOLD_PERIODS + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_PERIODS);
`endif

  // Channels start staggered across the period, snapped to the STEP grid.
  function automatic logic [CNT_W-1:0] duty_init(int i);
    return CNT_W'((i * (PERIOD / CH) / STEP) * STEP);
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] level_q;
  logic [CNT_W-1:0] fixed_duty;
  mode_e            mode_q;
  logic [BW-1:0]    blink_cnt;
  logic             blink_state;
  logic [CH-1:0]    lit;
  logic [CH-1:0]    dir_all;
  logic             wrap;

  assign wrap       = en && (cnt == PER);
  assign fixed_duty = (level_q > PER) ? PER : level_q;
  assign ch0_dir    = dir_all[0];

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] step_duty;
    logic             dir;
    logic             step_dir;
    logic [CNT_W:0]   eff;

    // Saturating triangle step; compares are widened so PERIOD-STEP and STEP never wrap.
    always_comb begin
      step_duty = duty;
      step_dir  = dir;
      if (dir) begin
        if ({1'b0, duty} >= PER_X - STP_X) begin
          step_duty = PER;
          step_dir  = 1'b0;
        end else begin
          step_duty = duty + STP;
        end
      end else begin
        if ({1'b0, duty} <= STP_X) begin
          step_duty = '0;
          step_dir  = 1'b1;
        end else begin
          step_duty = duty - STP;
        end
      end
    end

`ifdef BREATH_HOLD_EN
    logic [HW-1:0] hold;
    always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
        duty <= duty_init(g);
        dir  <= 1'b1;
        hold <= '0;
      end else if (wrap && mode_q == MODE_BREATHE) begin
        if (hold != '0) begin
          hold <= hold - HW'(1);
        end else begin
          duty <= step_duty;
          dir  <= step_dir;
          if (step_dir != dir) hold <= HOLD_INIT;
        end
      end
    end
`else
    always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
        duty <= duty_init(g);
        dir  <= 1'b1;
      end else if (wrap && mode_q == MODE_BREATHE) begin
        duty <= step_duty;
        dir  <= step_dir;
      end
    end
`endif

    always_comb begin
      case (mode_q)
        MODE_BREATHE: eff = {1'b0, duty};
        MODE_FIXED:   eff = {1'b0, fixed_duty};
        MODE_BLINK:   eff = blink_state ? FULL_X : '0;
        default:      eff = '0;
      endcase
    end

    assign lit[g]     = {1'b0, cnt} < eff;
    assign dir_all[g] = dir;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      mode_q      <= MODE_OFF;
      level_q     <= '0;
      blink_cnt   <= '0;
      blink_state <= 1'b0;
      period_tick <= 1'b0;
      led         <= UNLIT;
    end else begin
      period_tick <= wrap;
      led         <= en ? (lit ^ UNLIT) : UNLIT;
      if (!en || wrap) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
      // Mode and level only change on a period boundary so no period is cut short.
      if (wrap) begin
        mode_q  <= mode_e'(mode);
        level_q <= level;
        if (mode_q == MODE_BLINK) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_state <= ~blink_state;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
      end
      if (mode_q != MODE_BLINK) blink_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_breath_pwm_multi.sv
// tb/tb_breath_pwm_multi.sv - scoreboard bench for breath_pwm_multi
// Per-period lit counts, period lengths and ch0_dir are predicted by a period-level model.
module tb_breath_pwm_multi;
  localparam int CH = 2, CNT_W = 16, PERIOD = 99, STEP = 10, BLINK = 2, HOLD = 3;
`ifdef BREATH_HOLD_EN
  localparam int HOLD_LEN = HOLD;
`else
  localparam int HOLD_LEN = 0;
`endif

  logic             sys_clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b1;
  logic [1:0]       mode = 2'd1;
  logic [CNT_W-1:0] level = '0;
  logic [CH-1:0]    led;
  logic             period_tick;
  logic             ch0_dir;

  breath_pwm_multi #(
    .CH(CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP(STEP),
    .BLINK_PERIODS(BLINK), .ACTIVE_LOW(1'b1), .HOLD_PERIODS(HOLD)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .en(en), .mode(mode), .level(level),
    .led(led), .period_tick(period_tick), .ch0_dir(ch0_dir)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] l0;
    logic [15:0] l1;
    logic        dir0;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced once per PWM period.
  int m_duty[CH];
  bit m_dir[CH];
  int m_hold[CH];
  int m_mode_q, m_level_q, m_bcnt;
  bit m_bstate;
  int cur_mode = 1;
  int cur_level = 0;

  function automatic int eff(int ch);
    if (m_mode_q == 1) return m_duty[ch];
    if (m_mode_q == 2) return (m_level_q > PERIOD) ? PERIOD : m_level_q;
    if (m_mode_q == 3) return m_bstate ? PERIOD + 1 : 0;
    return 0;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_duty[c] = (c * (PERIOD / CH) / STEP) * STEP;
      m_dir[c]  = 1'b1;
      m_hold[c] = 0;
    end
    m_mode_q = 0; m_level_q = 0; m_bcnt = 0; m_bstate = 1'b0;
  endtask

  task automatic model_wrap(int nm, int nl);
    if (m_mode_q == 1) begin
      for (int c = 0; c < CH; c++) begin
        if (m_hold[c] > 0) begin
          m_hold[c]--;
        end else if (m_dir[c]) begin
          m_duty[c] += STEP;
          if (m_duty[c] >= PERIOD) begin m_duty[c] = PERIOD; m_dir[c] = 1'b0; m_hold[c] = HOLD_LEN; end
        end else begin
          m_duty[c] -= STEP;
          if (m_duty[c] <= 0) begin m_duty[c] = 0; m_dir[c] = 1'b1; m_hold[c] = HOLD_LEN; end
        end
      end
    end
    if (m_mode_q == 3) begin
      m_bcnt++;
      if (m_bcnt == BLINK) begin m_bcnt = 0; m_bstate = !m_bstate; end
    end else begin
      m_bcnt = 0;
    end
    m_mode_q = nm;
    m_level_q = nl;
  endtask

  // Runs one period from a tick cycle to the next; gap drops en for 37 cycles mid-period.
  task automatic run_period(int nm, int nl, bit gap);
    exp_t e;
    int   k, e0, e1;
    e0 = eff(0);
    e1 = eff(1);
    if (gap) begin
      k = $urandom_range(1, 60);
      e.len = 16'(k + 37 + PERIOD + 1);
      e.l0  = 16'(imin(k, e0) + e0);
      e.l1  = 16'(imin(k, e1) + e1);
      model_wrap(cur_mode, cur_level);
      e.dir0 = m_dir[0];
      sb.push_back(e);
      repeat (k) @(negedge sys_clk);
      en = 1'b0;
      repeat (37) @(negedge sys_clk);
      en = 1'b1;
      repeat (PERIOD + 1) @(negedge sys_clk);
    end else begin
      k = $urandom_range(1, PERIOD);
      e.len = 16'(PERIOD + 1);
      e.l0  = 16'(e0);
      e.l1  = 16'(e1);
      model_wrap(nm, nl);
      e.dir0 = m_dir[0];
      sb.push_back(e);
      repeat (k) @(negedge sys_clk);
      mode = 2'(nm);
      level = 16'(nl);
      cur_mode = nm;
      cur_level = nl;
      repeat (PERIOD + 1 - k) @(negedge sys_clk);
    end
  endtask

  // Monitor: accumulates lit cycles between ticks and checks against the scoreboard.
  int   mon_cyc = 0;
  int   mon_l0 = 0;
  int   mon_l1 = 0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge sys_clk);
      if (!rst) begin
        mon_cyc = 0; mon_l0 = 0; mon_l1 = 0;
      end else begin
        mon_cyc++;
        if (led[0] == 1'b0) mon_l0++;
        if (led[1] == 1'b0) mon_l1++;
        if (period_tick) begin
          if (sb.size() == 0) begin
            check("unexpected_tick", sb.size(), 1);
          end else begin
            mon_e = sb.pop_front();
            check("period_len", mon_cyc, int'(mon_e.len));
            check("lit_ch0", mon_l0, int'(mon_e.l0));
            check("lit_ch1", mon_l1, int'(mon_e.l1));
            check("ch0_dir", int'(ch0_dir), int'(mon_e.dir0));
          end
          mon_cyc = 0; mon_l0 = 0; mon_l1 = 0;
        end
      end
    end
  end

  initial begin
    int nm;
    model_reset();
    repeat (3) @(negedge sys_clk);
    check("reset_led", int'(led), 3);
    check("reset_tick", int'(period_tick), 0);
    check("reset_dir", int'(ch0_dir), 1);
    #2 rst = 1'b1;

    for (int p = 0; p < 30; p++) run_period(1, $urandom_range(0, 255), p == 14);

    for (int p = 0; p < 50; p++) begin
      nm = cur_mode;
      if ($urandom_range(0, 9) < 3) nm = $urandom_range(0, 3);
      run_period(nm, $urandom_range(0, 255), $urandom_range(0, 11) == 0);
    end

    run_period(1, 0, 1'b0);
    run_period(2, 150, 1'b0);
    run_period(2, 150, 1'b0);
    repeat (3) run_period(1, 0, 1'b0);
    repeat (6) run_period(3, 0, 1'b0);
    run_period(1, 0, 1'b0);
    run_period(1, 0, 1'b0);

    repeat (55) @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check("midrst_led", int'(led), 3);
    check("midrst_dir", int'(ch0_dir), 1);
    check("midrst_tick", int'(period_tick), 0);
    model_reset();
    @(negedge sys_clk);
    #2 rst = 1'b1;
    repeat (4) run_period(1, 0, 1'b0);

    repeat (3) @(negedge sys_clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
